// File: rtl/hamming1511_serial_checker.sv
// hamming1511_serial_checker: bit-serial Hamming(15,11) receiver that accumulates the syndrome, corrects one error and reports data/status.
// Ports: clk, RST (async, active-high), sl_in/shift (serial bit + enable),
// data_out/data_valid/syndrome/err_corrected (per-frame results),
// err_count (saturating corrected-frame count), busy (frame in progress).
module hamming1511_serial_checker #(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 RST,
  input  logic                 sl_in,
  input  logic                 shift,
  output logic [10:0]          data_out,
  output logic                 data_valid,
  output logic [3:0]           syndrome,
  output logic                 err_corrected,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 busy
);
  logic [3:0]           pos_q, pos_d, acc_q, acc_d, syn_q, syn_d, s;
  logic [15:1]          cap_q, cap_d, fixed;
  logic [15:0]          flip;
  logic [10:0]          data_q, data_d;
  logic                 valid_q, valid_d, ec_q, ec_d, last;
  logic [ERR_CNT_W-1:0] cnt_q, cnt_d;
  always_comb begin
    cap_d = cap_q;
    if (shift) cap_d[pos_q] = sl_in;
    last = shift && pos_q == 4'd15;
    // the 15th bit's contribution folds in here instead of going through acc
    s = acc_q ^ {4{sl_in}};
    // bit 0 of flip falls away, so s == 0 flips nothing
    flip = 16'd1 << s;
    fixed = cap_d ^ flip[15:1];
    pos_d = !shift ? pos_q : last ? 4'd1 : pos_q + 4'd1;
    acc_d = !shift ? acc_q : last ? 4'd0 : acc_q ^ (sl_in ? pos_q : 4'd0);
    valid_d = last;
    syn_d = last ? s : syn_q;
    ec_d = last ? s != 4'd0 : ec_q;
    data_d = last ? {fixed[15:9], fixed[7:5], fixed[3]} : data_q;
    cnt_d = last && s != 4'd0 && cnt_q != '1 ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      pos_q <= 4'd1;
      acc_q <= '0;
      cap_q <= '0;
      data_q <= '0;
      valid_q <= 1'b0;
      syn_q <= '0;
      ec_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      pos_q <= pos_d;
      acc_q <= acc_d;
      cap_q <= cap_d;
      data_q <= data_d;
      valid_q <= valid_d;
      syn_q <= syn_d;
      ec_q <= ec_d;
      cnt_q <= cnt_d;
    end
  end
  assign data_out = data_q;
  assign data_valid = valid_q;
  assign syndrome = syn_q;
  assign err_corrected = ec_q;
  assign err_count = cnt_q;
  assign busy = pos_q != 4'd1;
endmodule

// File: tb/tb_hamming1511_serial_checker.sv
// tb_hamming1511_serial_checker: directed bench with a frame-level reference model checked every cycle.
module tb_hamming1511_serial_checker;
  logic clk = 1'b0, RST = 1'b0, sl_in = 1'b0, shift = 1'b0;
  logic [10:0] data_out;
  logic        data_valid, err_corrected, busy;
  logic [3:0]  syndrome;
  logic [7:0]  err_count;
  int vecs = 0, errs = 0;
  logic chk_en = 1'b0;
  int dp [11] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};

  hamming1511_serial_checker #(.ERR_CNT_W(8)) dut (
    .clk(clk), .RST(RST), .sl_in(sl_in), .shift(shift),
    .data_out(data_out), .data_valid(data_valid), .syndrome(syndrome),
    .err_corrected(err_corrected), .err_count(err_count), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] synd(input logic [15:0] w);
    logic [3:0] r = 4'd0;
    for (int i = 1; i < 16; i++) if (w[i]) r ^= 4'(i);
    return r;
  endfunction

  function automatic logic [15:0] fix(input logic [15:0] w);
    logic [3:0] r = synd(w);
    if (r != 4'd0) w[r] = ~w[r];
    return w;
  endfunction

  function automatic logic [10:0] extract(input logic [15:0] w);
    logic [10:0] d;
    for (int k = 0; k < 11; k++) d[k] = w[dp[k]];
    return d;
  endfunction

  function automatic logic [15:0] encode(input logic [10:0] d);
    logic [15:0] w = 16'd0;
    logic [3:0] r;
    for (int k = 0; k < 11; k++) w[dp[k]] = d[k];
    r = synd(w);
    w[1] = r[0]; w[2] = r[1]; w[4] = r[2]; w[8] = r[3];
    return w;
  endfunction

  function automatic logic [15:0] put(input logic [15:0] w, input int n, input logic b);
    w[n + 1] = b;
    return w;
  endfunction

  // reference model: collects a frame, evaluates it as a whole at completion
  logic [15:0] fr;
  int          n, m_cnt;
  logic [10:0] m_data;
  logic [3:0]  m_syn;
  logic        m_valid, m_ec;
  always @(posedge clk or posedge RST) begin
    if (RST) begin
      fr <= 16'd0; n <= 0; m_cnt <= 0; m_data <= '0; m_syn <= '0; m_valid <= 1'b0; m_ec <= 1'b0;
    end else begin
      m_valid <= 1'b0;
      if (shift) begin
        fr <= put(fr, n, sl_in);
        n <= n == 14 ? 0 : n + 1;
        if (n == 14) begin
          m_valid <= 1'b1;
          m_syn <= synd(put(fr, n, sl_in));
          m_ec <= synd(put(fr, n, sl_in)) != 4'd0;
          m_data <= extract(fix(put(fr, n, sl_in)));
          if (synd(put(fr, n, sl_in)) != 4'd0 && m_cnt < 255) m_cnt <= m_cnt + 1;
        end
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (chk_en) begin
    check("valid", 32'(data_valid), 32'(m_valid));
    check("busy", 32'(busy), 32'(n != 0));
    check("data", 32'(data_out), 32'(m_data));
    check("syndrome", 32'(syndrome), 32'(m_syn));
    check("err_corr", 32'(err_corrected), 32'(m_ec));
    check("err_count", 32'(err_count), 32'(m_cnt));
  end

  task automatic send_bit(input logic b, input int gap);
    sl_in = b; shift = 1'b1;
    @(posedge clk); #1;
    shift = 1'b0; sl_in = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic send_frame(input logic [15:0] w, input int gmax);
    for (int i = 1; i < 16; i++) send_bit(w[i], i == 15 ? 0 : $urandom_range(gmax, 0));
  endtask

  task automatic lit(input string nm, input logic v, input logic [10:0] d, input logic [3:0] s, input logic e, input logic [7:0] c);
    @(negedge clk);
    check({nm, ".valid"}, 32'(data_valid), 32'(v));
    check({nm, ".data"}, 32'(data_out), 32'(d));
    check({nm, ".syn"}, 32'(syndrome), 32'(s));
    check({nm, ".ec"}, 32'(err_corrected), 32'(e));
    check({nm, ".cnt"}, 32'(err_count), 32'(c));
  endtask

  initial begin
    logic [15:0] w;
    #1 RST = 1'b1;
    @(posedge clk); #1 RST = 1'b0;
    chk_en = 1'b1;
    lit("reset", 0, 11'h000, 4'd0, 0, 8'd0);
    check("reset.busy", 32'(busy), 32'd0);
    #1;
    send_frame(16'h0000, 0);
    lit("zero", 1, 11'h000, 4'd0, 0, 8'd0);
    #1;
    send_frame(16'hFFFE, 0);
    lit("ones", 1, 11'h7FF, 4'd0, 0, 8'd0);
    #1;
    send_frame(16'h000E, 0);
    lit("d0", 1, 11'h001, 4'd0, 0, 8'd0);
    #1;
    send_frame(16'h002E, 0);
    lit("d0_p5", 1, 11'h001, 4'd5, 1, 8'd1);
    #1;
    send_frame(16'h0100, 3);
    lit("p8_gaps", 1, 11'h000, 4'd8, 1, 8'd2);
    #1;
    for (int i = 1; i < 8; i++) send_bit(1'b1, 0);
    RST = 1'b1;
    lit("midrst", 0, 11'h000, 4'd0, 0, 8'd0);
    check("midrst.busy", 32'(busy), 32'd0);
    @(posedge clk); #1 RST = 1'b0;
    send_frame(16'h000E, 1);
    lit("after_rst", 1, 11'h001, 4'd0, 0, 8'd0);
    #1;
    w = encode(11'h5A3) ^ 16'h1000;
    send_frame(w, 2);
    lit("d5a3_p12", 1, 11'h5A3, 4'd12, 1, 8'd1);
    #1;
    for (int k = 0; k < 6; k++) begin
      w = encode(11'($urandom));
      if (k[0]) w[k + 1] = ~w[k + 1];
      send_frame(w, 2);
    end
    for (int k = 0; k < 260; k++) begin
      w = encode(11'($urandom));
      w[(k % 15) + 1] = ~w[(k % 15) + 1];
      send_frame(w, 0);
    end
    lit("saturate", 1, m_data, m_syn, 1, 8'd255);
    repeat (3) @(posedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
